// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and the round-robin grant helper for the I/D cache to memory arbiter.
package cache_mem_arbiter_pkg;

    localparam int LINE_OFFSET = 5;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        DONE
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } grant_t;

    // req[0] is the I-cache, req[1] the D-cache; a tie goes to whoever did not win last time.
    function automatic grant_t rr_pick(input logic [1:0] req, input grant_t last);
        case (req)
            2'b01:   rr_pick = GRANT_I;
            2'b10:   rr_pick = GRANT_D;
            2'b11:   rr_pick = (last == GRANT_I) ? GRANT_D : GRANT_I;
            default: rr_pick = GRANT_I;
        endcase
    endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// Serialises I-cache reads and D-cache reads/writebacks onto one physical-memory port,
// one line transfer at a time, with a registered one-cycle response back to the client.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic                  i_resp,
    output logic [LINE_WIDTH-1:0] i_rdata,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_resp,
    output logic [LINE_WIDTH-1:0] d_rdata,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic                  pmem_resp,
    input  logic [LINE_WIDTH-1:0] pmem_rdata
);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    grant_t                r_last_grant;
    grant_t                w_grant;
    logic                  w_take;
    logic [ADDR_WIDTH-1:0] w_req_addr;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic                  r_is_write;
    logic [LINE_WIDTH-1:0] r_i_rdata;
    logic [LINE_WIDTH-1:0] r_d_rdata;

    assign w_grant    = rr_pick({d_read | d_write, i_read}, r_last_grant);
    assign w_take     = (r_state == IDLE) && (i_read || d_read || d_write);
    assign w_req_addr = (w_grant == GRANT_I) ? i_address : d_address;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_next_state = (w_grant == GRANT_I) ? SERVE_I : SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                pmem_read  = !r_is_write;
                pmem_write = r_is_write;
                if (pmem_resp) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                i_resp       = (r_last_grant == GRANT_I);
                d_resp       = (r_last_grant == GRANT_D);
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Holding registers are captured only at grant, so client inputs may wander during SERVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GRANT_D;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_is_write   <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            if (w_take) begin
                r_last_grant <= w_grant;
                r_addr       <= {w_req_addr[ADDR_WIDTH-1:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
                r_wdata      <= d_wdata;
                // A simultaneous d_read/d_write is illegal; the write wins.
                r_is_write   <= (w_grant == GRANT_D) && d_write;
            end
            if (pmem_resp && (r_state == SERVE_I)) begin
                r_i_rdata <= pmem_rdata;
            end
            if (pmem_resp && (r_state == SERVE_D)) begin
                r_d_rdata <= pmem_rdata;
            end
        end
    end

    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;
    assign i_rdata      = r_i_rdata;
    assign d_rdata      = r_d_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: arbitration order, strobe timing, address
// alignment, input isolation during a transfer, and asynchronous reset mid-transfer.
module tb_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic          i_resp;
    logic [LW-1:0] i_rdata;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic          d_resp;
    logic [LW-1:0] d_rdata;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic          pmem_resp;
    logic [LW-1:0] pmem_rdata;

    int errors = 0;
    int checks = 0;

    cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_resp       (i_resp),
        .i_rdata      (i_rdata),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_resp       (d_resp),
        .d_rdata      (d_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata)
    );

    always #5 clk = ~clk;

    // Clients must never raise d_read and d_write together.
    always @(negedge clk) begin
        if (rst_n) begin
            assert (!(d_read && d_write)) else $error("illegal d_read and d_write together");
        end
    end

    task automatic check(input string tag, input logic [LW-1:0] observed, input logic [LW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle memory completion pulse, sampled at the next rising edge.
    task automatic mem_respond(input logic [LW-1:0] data);
        pmem_resp  = 1'b1;
        pmem_rdata = data;
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pmem_read"},    LW'(pmem_read),    '0);
        check({tag, ".pmem_write"},   LW'(pmem_write),   '0);
        check({tag, ".pmem_address"}, LW'(pmem_address), '0);
        check({tag, ".pmem_wdata"},   pmem_wdata,        '0);
        check({tag, ".i_resp"},       LW'(i_resp),       '0);
        check({tag, ".d_resp"},       LW'(d_resp),       '0);
        check({tag, ".i_rdata"},      i_rdata,           '0);
        check({tag, ".d_rdata"},      d_rdata,           '0);
    endtask

    localparam logic [LW-1:0] LINE_AA = {32{8'hAA}};
    localparam logic [LW-1:0] LINE_11 = {32{8'h11}};
    localparam logic [LW-1:0] LINE_22 = {32{8'h22}};
    localparam logic [LW-1:0] LINE_33 = {32{8'h33}};
    localparam logic [LW-1:0] LINE_44 = {32{8'h44}};
    localparam logic [LW-1:0] LINE_55 = {32{8'h55}};
    localparam logic [LW-1:0] LINE_66 = {32{8'h66}};
    localparam logic [LW-1:0] WLINE   = {8{32'h1234_5678}};
    localparam logic [LW-1:0] WLINE2  = {8{32'hDEAD_BEEF}};

    initial begin
        rst_n      = 1'b0;
        i_read     = 1'b0;
        i_address  = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_address  = '0;
        d_wdata    = '0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;

        // Reset state.
        repeat (2) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // First conflict after reset: I wins, D follows from the next IDLE cycle.
        i_read = 1'b1; i_address = 32'h0000_0100;
        d_read = 1'b1; d_address = 32'h0000_0200;
        tick();
        check("c1.i_first.pmem_read", LW'(pmem_read), LW'(1'b1));
        check("c1.i_first.addr", LW'(pmem_address), LW'(32'h0000_0100));
        tick();
        mem_respond(LINE_11);
        check("c1.i_resp", LW'(i_resp), LW'(1'b1));
        check("c1.d_resp_low", LW'(d_resp), '0);
        check("c1.i_rdata", i_rdata, LINE_11);
        i_read = 1'b0;
        tick();
        check("c1.idle_gap.pmem_read", LW'(pmem_read), '0);
        check("c1.idle_gap.i_resp", LW'(i_resp), '0);
        tick();
        check("c1.d_second.pmem_read", LW'(pmem_read), LW'(1'b1));
        check("c1.d_second.addr", LW'(pmem_address), LW'(32'h0000_0200));
        mem_respond(LINE_22);
        check("c1.d_resp", LW'(d_resp), LW'(1'b1));
        check("c1.d_rdata", d_rdata, LINE_22);
        d_read = 1'b0;
        tick();

        // Lone I read at an unaligned address.
        i_read = 1'b1; i_address = 32'h0000_0064;
        tick();
        check("iread.pmem_read", LW'(pmem_read), LW'(1'b1));
        check("iread.pmem_write", LW'(pmem_write), '0);
        check("iread.addr_aligned", LW'(pmem_address), LW'(32'h0000_0060));
        tick();
        check("iread.wait.pmem_read", LW'(pmem_read), LW'(1'b1));
        mem_respond(LINE_AA);
        check("iread.i_resp", LW'(i_resp), LW'(1'b1));
        check("iread.i_rdata", i_rdata, LINE_AA);
        check("iread.done.pmem_read", LW'(pmem_read), '0);
        i_read = 1'b0;
        tick();
        check("iread.resp_one_cycle", LW'(i_resp), '0);

        // Second conflict, last grant was I: D wins, then I.
        i_read = 1'b1; i_address = 32'h0000_0300;
        d_read = 1'b1; d_address = 32'h0000_0400;
        tick();
        check("c2.d_first.addr", LW'(pmem_address), LW'(32'h0000_0400));
        mem_respond(LINE_33);
        check("c2.d_resp", LW'(d_resp), LW'(1'b1));
        check("c2.i_resp_low", LW'(i_resp), '0);
        check("c2.d_rdata", d_rdata, LINE_33);
        d_read = 1'b0;
        tick();
        tick();
        check("c2.i_second.addr", LW'(pmem_address), LW'(32'h0000_0300));
        check("c2.i_second.pmem_read", LW'(pmem_read), LW'(1'b1));
        mem_respond(LINE_44);
        check("c2.i_resp", LW'(i_resp), LW'(1'b1));
        check("c2.i_rdata", i_rdata, LINE_44);
        i_read = 1'b0;
        tick();

        // Lone D write; client inputs change while the transfer is in flight.
        d_write = 1'b1; d_address = 32'h1000_0020; d_wdata = WLINE;
        tick();
        check("dwr.pmem_write", LW'(pmem_write), LW'(1'b1));
        check("dwr.no_read", LW'(pmem_read), '0);
        check("dwr.addr", LW'(pmem_address), LW'(32'h1000_0020));
        check("dwr.wdata", pmem_wdata, WLINE);
        d_address = 32'h2000_0040; d_wdata = WLINE2;
        tick();
        check("dwr.addr_held", LW'(pmem_address), LW'(32'h1000_0020));
        check("dwr.wdata_held", pmem_wdata, WLINE);
        check("dwr.still_writing", LW'(pmem_write), LW'(1'b1));
        mem_respond(WLINE);
        check("dwr.d_resp", LW'(d_resp), LW'(1'b1));
        check("dwr.done.pmem_write", LW'(pmem_write), '0);
        check("dwr.done.pmem_read", LW'(pmem_read), '0);
        d_write = 1'b0;
        tick();

        // Stray memory response while idle is ignored.
        mem_respond(LINE_66);
        check("stray.i_resp", LW'(i_resp), '0);
        check("stray.d_resp", LW'(d_resp), '0);
        check("stray.d_rdata_kept", d_rdata, WLINE);
        tick();
        check("stray.later.d_resp", LW'(d_resp), '0);

        // Client keeps i_read high past i_resp: a fresh transfer is served.
        i_read = 1'b1; i_address = 32'h0000_0500;
        tick();
        mem_respond(LINE_55);
        check("hold.i_resp", LW'(i_resp), LW'(1'b1));
        $display("note: i_read held past i_resp is a protocol violation; expecting a fresh transfer");
        tick();
        tick();
        check("hold.reissue.pmem_read", LW'(pmem_read), LW'(1'b1));
        check("hold.reissue.addr", LW'(pmem_address), LW'(32'h0000_0500));
        mem_respond(LINE_66);
        check("hold.reissue.i_resp", LW'(i_resp), LW'(1'b1));
        check("hold.reissue.i_rdata", i_rdata, LINE_66);
        i_read = 1'b0;
        tick();

        // Asynchronous reset in the middle of a D write.
        d_write = 1'b1; d_address = 32'h0000_0600; d_wdata = WLINE2;
        tick();
        check("rstmid.pmem_write", LW'(pmem_write), LW'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rstmid");
        d_write = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        mem_respond(LINE_AA);
        check("rstmid.late.d_resp", LW'(d_resp), '0);
        check("rstmid.late.i_resp", LW'(i_resp), '0);
        check("rstmid.late.pmem_write", LW'(pmem_write), '0);
        check("rstmid.late.d_rdata", d_rdata, '0);
        tick();
        check("rstmid.after.d_resp", LW'(d_resp), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
